// File: rtl/byte_add_sequencer.sv
// Two-requester multi-byte adder that time-shares a single 8-bit adder.
// Operands are consumed LSB byte first, with the carry chained through a register.

module eight_add_module (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
endmodule

module byte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [8*NBYTES-1:0]   r0_a,
  input  logic [8*NBYTES-1:0]   r0_b,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [8*NBYTES-1:0]   r1_a,
  input  logic [8*NBYTES-1:0]   r1_b,
  output logic                  done,
  output logic                  done_id,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  busy
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_owner;
  logic            r_last_grant;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_done_id;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_last_byte;
  logic [7:0]      w_sum_byte;
  logic            w_add_cout;
  logic [W-1:0]    w_sum_next;

  // Handshake: a request transfers on the rising edge where rX_valid & rX_ready;
  // ready is only offered in IDLE, and valid may be withdrawn freely before that.
  assign w_grant0 = r0_valid & (~r1_valid | r_last_grant);
  assign w_grant1 = r1_valid & (~r0_valid | ~r_last_grant);

  assign w_last_byte = (r_cnt == CW'(NBYTES - 1));

  eight_add_module u_add (
    .i_a    (r_a[7:0]),
    .i_b    (r_b[7:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum_byte),
    .o_cout (w_add_cout)
  );

  // Sum bytes enter at the top and shift down, so after NBYTES steps byte 0 sits at the LSB.
  assign w_sum_next = (r_sum >> 8) | (W'(w_sum_byte) << (W - 8));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        r0_ready = w_grant0;
        r1_ready = w_grant1;
        if (w_grant0 | w_grant1) begin
          w_state_next = S_ADD;
        end
      end
      S_ADD: begin
        if (w_last_byte) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_result     <= '0;
      r_cout       <= 1'b0;
      r_done_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_a          <= w_grant1 ? r1_a : r0_a;
            r_b          <= w_grant1 ? r1_b : r0_b;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
          end
        end
        S_ADD: begin
          r_a     <= r_a >> 8;
          r_b     <= r_b >> 8;
          r_sum   <= w_sum_next;
          r_carry <= w_add_cout;
          r_cnt   <= r_cnt + CW'(1);
          // Visible outputs update only as DONE is entered, so they hold between ops.
          if (w_last_byte) begin
            r_result  <= w_sum_next;
            r_cout    <= w_add_cout;
            r_done_id <= r_owner;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result  = r_result;
  assign cout    = r_cout;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_byte_add_sequencer.sv
// Directed bench for byte_add_sequencer (NBYTES=4): vector table, arbitration
// sequence, mid-operation reset and output hold behaviour.

module tb_byte_add_sequencer;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int EW     = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         done, done_id, cout, busy;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  last_res;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
  } vec_t;

  vec_t vecs[9];

  byte_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_a     (r0_a),
    .r0_b     (r0_b),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_a     (r1_a),
    .r1_b     (r1_b),
    .done     (done),
    .done_id  (done_id),
    .result   (result),
    .cout     (cout),
    .busy     (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // scoreboard: every done pulse must match the oldest expected {id, cout, result}
  always begin
    logic [EW-1:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (r0_ready && r1_ready) begin
        bad++;
        $display("FAIL both_ready: r0_ready=%0b r1_ready=%0b, required at most one", r0_ready, r1_ready);
      end
      if (done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: id=%0b result=%h, no op outstanding", done_id, result);
        end else begin
          e = exp_q.pop_front();
          if ({done_id, cout, result} !== e) begin
            bad++;
            $display("FAIL done_data: got id=%0b cout=%0b result=%h, expected id=%0b cout=%0b result=%h",
                     done_id, cout, result, e[W+1], e[W], e[W-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
  endtask

  // driver: one full operation, checking acceptance, latency and output hold
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ec);
    int lat;
    bit seen;
    bit held;
    @(negedge clk);
    if (id) begin
      r1_valid = 1'b1; r1_a = a; r1_b = b;
    end else begin
      r0_valid = 1'b1; r0_a = a; r0_b = b;
    end
    exp_q.push_back({id, ec, er});
    #1;
    check("ready", W'(id ? r1_ready : r0_ready), W'(1));
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r0_a = $urandom(); r0_b = $urandom();
    r1_a = $urandom(); r1_b = $urandom();
    seen = 1'b0;
    held = 1'b1;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
      else if (result !== last_res) held = 1'b0;
    end
    check("done_latency", W'(seen ? lat : 0), W'(NBYTES + 1));
    check("result_held_while_busy", W'(held), W'(1));
    last_res = er;
    @(negedge clk);
    #1;
    check("after_done", {done, busy, cout, result}, {1'b0, 1'b0, ec, er});
  endtask

  initial begin
    int cyc;
    int ngrant;
    int ndone;
    int done_cyc[3];
    logic [2:0] grants;
    bit drop;

    vecs[0] = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
    vecs[1] = '{1'b1, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[4] = '{1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0};
    vecs[5] = '{1'b1, 32'hDEADBEEF, 32'h01234567, 32'hDFD10456, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    vecs[7] = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[8] = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    do_reset();

    // reset state
    @(negedge clk);
    #1;
    check("reset_outputs", {done, done_id, cout, busy, r0_ready, r1_ready, result},
          {6'b0, {W{1'b0}}});

    // vector table
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c);
    end

    // reset during the 2nd ADD cycle of an r1 op
    @(negedge clk);
    r1_valid = 1'b1; r1_a = 32'h01010101; r1_b = 32'h02020202;
    #1;
    check("rst_op_ready", W'(r1_ready), W'(1));
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("after_mid_reset", {done, busy, cout, result}, {3'b000, 1'b0, {W{1'b0}}});
    rst = 1'b0;
    last_res = '0;
    repeat (8) @(negedge clk);
    do_op(1'b0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0);

    // both requesters held high from reset for three ops
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 1'b1; r0_a = 32'h00000010; r0_b = 32'h00000020;
    r1_valid = 1'b1; r1_a = 32'hF0000000; r1_b = 32'h20000000;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'h00000030});
    exp_q.push_back({1'b1, 1'b1, 32'h10000000});
    exp_q.push_back({1'b0, 1'b0, 32'h00000030});
    cyc = 0; ngrant = 0; ndone = 0; grants = '0; drop = 1'b0;
    done_cyc[0] = 0; done_cyc[1] = 0; done_cyc[2] = 0;
    #1;
    while (ndone < 3 && cyc < 60) begin
      if (drop) begin
        r0_valid = 1'b0;
        r1_valid = 1'b0;
      end
      if ((r0_ready || r1_ready) && ngrant < 3) begin
        grants[ngrant] = r1_ready;
        ngrant++;
        if (ngrant == 3) drop = 1'b1;
      end
      if (done) begin
        done_cyc[ndone] = cyc;
        ndone++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("rr_grant_count", W'(ngrant), W'(3));
    check("rr_grant_order", W'(grants), W'(3'b010));
    check("rr_done_count", W'(ndone), W'(3));
    check("rr_done_gap1", W'(done_cyc[1] - done_cyc[0]), W'(NBYTES + 2));
    check("rr_done_gap2", W'(done_cyc[2] - done_cyc[1]), W'(NBYTES + 2));
    last_res = 32'h00000030;

    // result/cout hold after the pulse, then the next op replaces them
    repeat (5) @(negedge clk);
    #1;
    check("hold_after_done", {cout, result}, {1'b0, 32'h00000030});
    do_op(1'b1, 32'hFFFF0000, 32'h00010000, 32'h00000000, 1'b1);

    repeat (3) @(negedge clk);
    check("exp_q_drained", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
